rgb2hsv_pipe: RTL

RGB2HSV_PIPE -- requirements
Module: rgb2hsv_pipe

---
 rtl/rgb2hsv_pkg.sv | 23 ++
 rtl/rgb2hsv_pipe_div.sv | 78 +++++++
 rtl/rgb2hsv_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared constants and types for the RGB to HSV pipeline.
package rgb2hsv_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Which component supplied the maximum; ties resolve R, then G, then B.
  typedef enum logic [1:0] {
    IDX_R,
    IDX_G,
    IDX_B
  } max_idx_e;

  // Hue units per 60-degree sector: floor(2^w / 6).
  function automatic int unsigned hue_seg(input int unsigned w);
    return (32'd1 << w) / 32'd6;
  endfunction

  // Input-to-output latency in ce-high cycles.
  function automatic int unsigned pipe_latency(input int unsigned w);
    return w + 32'd3;
  endfunction

endpackage

// File: rtl/rgb2hsv_pipe_div.sv
// hsv_div_pipe: unsigned restoring divider, one quotient bit per stage over W
// stages. The caller guarantees quotient < 2^W; a zero divisor yields 0.
module hsv_div_pipe #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic [2*W-1:0] dividend_i,
  input  logic [W-1:0]   divisor_i,
  output logic [W-1:0]   quot_o
);

  logic [2*W-1:0] rem_q  [W];
  logic [2*W-1:0] rem_d  [W];
  logic [2*W-1:0] rem_in [W];
  logic [W-1:0]   dvs_q  [W];
  logic [W-1:0]   dvs_d  [W];
  logic [W-1:0]   dvs_in [W];
  logic [W-1:0]   quo_q  [W];
  logic [W-1:0]   quo_d  [W];
  logic [W-1:0]   quo_in [W];
  logic [W-1:0]   zero_q;
  logic [W-1:0]   zero_d;
  logic [W-1:0]   zero_in;

  // Stage inputs: stage 0 takes the ports, later stages the previous stage.
  always_comb begin
    rem_in[0]  = dividend_i;
    dvs_in[0]  = divisor_i;
    quo_in[0]  = '0;
    zero_in    = '0;
    zero_in[0] = (divisor_i == '0);
    for (int unsigned s = 1; s < W; s++) begin
      rem_in[s]  = rem_q[s-1];
      dvs_in[s]  = dvs_q[s-1];
      quo_in[s]  = quo_q[s-1];
      zero_in[s] = zero_q[s-1];
    end
  end

  // One restoring step per stage, resolving quotient bits MSB first.
  always_comb begin : step
    logic [2*W-1:0] trial;
    logic           ge;
    trial  = '0;
    ge     = 1'b0;
    zero_d = zero_in;
    for (int unsigned s = 0; s < W; s++) begin
      trial            = {{W{1'b0}}, dvs_in[s]} << (W - 1 - s);
      ge               = (rem_in[s] >= trial);
      rem_d[s]         = ge ? (rem_in[s] - trial) : rem_in[s];
      dvs_d[s]         = dvs_in[s];
      quo_d[s]         = quo_in[s];
      quo_d[s][W-1-s]  = ge;
    end
  end

  // Stage registers, held while ce is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < W; s++) begin
        rem_q[s] <= '0;
        dvs_q[s] <= '0;
        quo_q[s] <= '0;
      end
      zero_q <= '0;
    end else if (ce) begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      zero_q <= zero_d;
    end
  end

  assign quot_o = zero_q[W-1] ? '0 : quo_q[W-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe: pipelined RGB to HSV converter, latency DATA_W+3 ce cycles.
// Optional skin-tone flag output enabled by macro RGB2HSV_PIPE_SKIN_EN.
module rgb2hsv_pipe
  import rgb2hsv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef RGB2HSV_PIPE_SKIN_EN
  ,
  parameter int H_LO = 0,
  parameter int H_HI = 30,
  parameter int S_LO = 40,
  parameter int S_HI = 200
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] G,
  input  logic [DATA_W-1:0] B,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_de,
  output logic [DATA_W-1:0] H,
  output logic [DATA_W-1:0] S,
  output logic [DATA_W-1:0] V,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_de
`ifdef RGB2HSV_PIPE_SKIN_EN
  ,
  output logic              skin
`endif
);

  localparam int unsigned HUE_SEG    = hue_seg(DATA_W);
  localparam int unsigned DIV_STAGES = pipe_latency(DATA_W) - 3;

  localparam logic [DATA_W-1:0] HSEG   = DATA_W'(HUE_SEG);
  localparam logic [DATA_W-1:0] VMAX   = '1;
  localparam logic [DATA_W:0]   BASE_G = (DATA_W+1)'(2 * HUE_SEG);
  localparam logic [DATA_W:0]   BASE_B = (DATA_W+1)'(4 * HUE_SEG);
  localparam logic [DATA_W:0]   HFULL  = (DATA_W+1)'(6 * HUE_SEG);

  // Per-pixel data that rides alongside the dividers.
  typedef struct packed {
    max_idx_e          idx;
    logic              neg;
    logic              dz;
    logic [DATA_W-1:0] v;
    logic              hs;
    logic              vs;
    logic              de;
  } side_t;

  // Stage 1
  logic [DATA_W-1:0] r_q, g_q, b_q;
  logic              hs1_q, vs1_q, de1_q;

  // Stage 2
  logic [2*DATA_W-1:0] sdvd_q, sdvd_d;
  logic [2*DATA_W-1:0] hdvd_q, hdvd_d;
  logic [DATA_W-1:0]   delta_q, delta_d;
  side_t               side2_q, side2_d;

  // Divider-aligned side data
  side_t side_q [DIV_STAGES];

  // Final stage
  logic [DATA_W-1:0] sq, hq;
  logic [DATA_W-1:0] h_q, h_d, s_q, s_d, v_q, v_d;
  logic              hs_q, vs_q, de_q;
`ifdef RGB2HSV_PIPE_SKIN_EN
  logic              skin_q, skin_d;
`endif

  // Max/min, delta and sign/magnitude hue numerator from the registered pixel.
  always_comb begin : stage2
    logic [DATA_W-1:0] mx, mn, pa, pb, nabs;
    logic              neg;
    side2_d = '0;
    mx      = r_q;
    pa      = g_q;
    pb      = b_q;
    side2_d.idx = IDX_R;
    if (r_q >= g_q && r_q >= b_q) begin
      side2_d.idx = IDX_R;
      mx = r_q;
      pa = g_q;
      pb = b_q;
    end else if (g_q >= b_q) begin
      side2_d.idx = IDX_G;
      mx = g_q;
      pa = b_q;
      pb = r_q;
    end else begin
      side2_d.idx = IDX_B;
      mx = b_q;
      pa = r_q;
      pb = g_q;
    end
    mn = r_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    delta_d = mx - mn;
    neg     = (pa < pb);
    nabs    = neg ? (pb - pa) : (pa - pb);
    sdvd_d  = {{DATA_W{1'b0}}, delta_d} * {{DATA_W{1'b0}}, VMAX};
    hdvd_d  = {{DATA_W{1'b0}}, nabs} * {{DATA_W{1'b0}}, HSEG};
    side2_d.neg = neg;
    side2_d.dz  = (delta_d == '0);
    side2_d.v   = mx;
    side2_d.hs  = hs1_q;
    side2_d.vs  = vs1_q;
    side2_d.de  = de1_q;
  end

  hsv_div_pipe #(.W(DIV_STAGES)) u_div_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .dividend_i (sdvd_q),
    .divisor_i  (side2_q.v),
    .quot_o     (sq)
  );

  hsv_div_pipe #(.W(DIV_STAGES)) u_div_h (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .dividend_i (hdvd_q),
    .divisor_i  (delta_q),
    .quot_o     (hq)
  );

  // Hue assembly: sector base plus/minus fraction, wrapping below zero.
  always_comb begin : assemble
    side_t             sd;
    logic [DATA_W:0]   base, fr, hsum;
    sd   = side_q[DIV_STAGES-1];
    fr   = {1'b0, hq};
    base = '0;
    hsum = '0;
    case (sd.idx)
      IDX_G:   base = BASE_G;
      IDX_B:   base = BASE_B;
      default: base = '0;
    endcase
    if (sd.dz)           hsum = '0;
    else if (!sd.neg)    hsum = base + fr;
    else if (base >= fr) hsum = base - fr;
    else                 hsum = HFULL + base - fr;
    h_d = DATA_W'(hsum);
    s_d = sd.dz ? '0 : sq;
    v_d = sd.v;
`ifdef RGB2HSV_PIPE_SKIN_EN
    skin_d = (int'(h_d) >= H_LO) && (int'(h_d) <= H_HI) &&
             (int'(s_d) >= S_LO) && (int'(s_d) <= S_HI);
`endif
  end

  // All pipeline registers: reset clears, ce advances, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      sdvd_q  <= '0;
      hdvd_q  <= '0;
      delta_q <= '0;
      side2_q <= '0;
      for (int unsigned s = 0; s < DIV_STAGES; s++) side_q[s] <= '0;
      h_q     <= '0;
      s_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
`ifdef RGB2HSV_PIPE_SKIN_EN
      skin_q  <= 1'b0;
`endif
    end else if (ce) begin
      r_q     <= R;
      g_q     <= G;
      b_q     <= B;
      hs1_q   <= in_hsync;
      vs1_q   <= in_vsync;
      de1_q   <= in_de;
      sdvd_q  <= sdvd_d;
      hdvd_q  <= hdvd_d;
      delta_q <= delta_d;
      side2_q <= side2_d;
      side_q[0] <= side2_q;
      for (int unsigned s = 1; s < DIV_STAGES; s++) side_q[s] <= side_q[s-1];
      h_q     <= h_d;
      s_q     <= s_d;
      v_q     <= v_d;
      hs_q    <= side_q[DIV_STAGES-1].hs;
      vs_q    <= side_q[DIV_STAGES-1].vs;
      de_q    <= side_q[DIV_STAGES-1].de;
`ifdef RGB2HSV_PIPE_SKIN_EN
      skin_q  <= skin_d;
`endif
    end
  end

  assign H         = h_q;
  assign S         = s_q;
  assign V         = v_q;
  assign out_hsync = hs_q;
  assign out_vsync = vs_q;
  assign out_de    = de_q;
`ifdef RGB2HSV_PIPE_SKIN_EN
  assign skin      = skin_q;
`endif

endmodule
